raifes_hasti_dbus_interconnect: RTL

- Parametrised single-master, N-slave AHB-Lite (HASTI) data-bus interconnect; sits between the dmem sync-to-HASTI bridge and the on-chip RAM and periphery slaves.
- Generalises the fixed 0x81 periphery decode to NUM_SLAVES base/mask regions.
- Adds data-phase-tracked return muxing of hrdata/hready/hresp, a built-in default slave for unmapped addresses, and optional hung-slave timeout.

---
 rtl/raifes_hasti_dbus_interconnect_pkg.sv | 45 ++++
 rtl/raifes_hasti_dbus_interconnect_if.sv | 59 +++++
 rtl/raifes_hasti_dbus_interconnect_default_slave.sv | 50 +++++
 rtl/raifes_hasti_dbus_interconnect.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/raifes_hasti_dbus_interconnect_pkg.sv
// ============================================================================
// raifes_hasti_dbus_interconnect_pkg: HASTI widths/encodings and dbus decode constants.
// Rev 1.0
// ============================================================================
`default_nettype none

package raifes_hasti_dbus_interconnect_pkg;

  // HASTI bus geometry and encodings
  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_RESP_WIDTH-1:0] HRESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HRESP_ERROR = 1'b1;

  // Data-phase select: codes 0..NUM_SLAVES-1 name a slot, two reserved codes above
  localparam int DSEL_WIDTH = 4;
  typedef logic [DSEL_WIDTH-1:0] dsel_t;
  localparam dsel_t DSEL_NONE    = 4'hF;
  localparam dsel_t DSEL_DEFAULT = 4'hE;

  localparam logic [HASTI_ADDR_WIDTH-1:0] DBUS_RAM_BASE    = 32'h0000_0000;
  localparam logic [HASTI_ADDR_WIDTH-1:0] DBUS_PERIPH_BASE = 32'h8100_0000;
  localparam logic [HASTI_ADDR_WIDTH-1:0] DBUS_REGION_MASK = 32'hFF00_0000;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic addr_hit(input logic [HASTI_ADDR_WIDTH-1:0] addr,
                                    input logic [HASTI_ADDR_WIDTH-1:0] base,
                                    input logic [HASTI_ADDR_WIDTH-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/raifes_hasti_dbus_interconnect_if.sv
// ============================================================================
// raifes_hasti_dbus_interconnect_if: master-side and slave-side HASTI signals of the dbus.
// Rev 1.0
// ============================================================================
`default_nettype none

interface raifes_hasti_dbus_interconnect_if #(
  parameter int NUM_SLAVES = 2
) ();
  import raifes_hasti_dbus_interconnect_pkg::*;

  logic [HASTI_ADDR_WIDTH-1:0]             m_haddr;
  logic                                    m_hwrite;
  logic                                    m_hmastlock;
  logic [HASTI_SIZE_WIDTH-1:0]             m_hsize;
  logic [HASTI_BURST_WIDTH-1:0]            m_hburst;
  logic [HASTI_PROT_WIDTH-1:0]             m_hprot;
  logic [HASTI_TRANS_WIDTH-1:0]            m_htrans;
  logic [HASTI_BUS_WIDTH-1:0]              m_hwdata;
  logic [HASTI_BUS_WIDTH-1:0]              m_hrdata;
  logic                                    m_hready;
  logic [HASTI_RESP_WIDTH-1:0]             m_hresp;

  logic [NUM_SLAVES-1:0]                   s_hsel;
  logic [HASTI_ADDR_WIDTH-1:0]             s_haddr;
  logic                                    s_hwrite;
  logic [HASTI_SIZE_WIDTH-1:0]             s_hsize;
  logic [HASTI_BURST_WIDTH-1:0]            s_hburst;
  logic                                    s_hmastlock;
  logic [HASTI_PROT_WIDTH-1:0]             s_hprot;
  logic [HASTI_TRANS_WIDTH-1:0]            s_htrans;
  logic [HASTI_BUS_WIDTH-1:0]              s_hwdata;
  logic                                    s_hreadyin;
  logic [NUM_SLAVES*HASTI_BUS_WIDTH-1:0]   s_hrdata;
  logic [NUM_SLAVES-1:0]                   s_hready;
  logic [NUM_SLAVES*HASTI_RESP_WIDTH-1:0]  s_hresp;

  modport master (
    output m_haddr, m_hwrite, m_hmastlock, m_hsize, m_hburst, m_hprot, m_htrans, m_hwdata,
    input  m_hrdata, m_hready, m_hresp
  );

  modport slave (
    input  s_hsel, s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans,
           s_hwdata, s_hreadyin,
    output s_hrdata, s_hready, s_hresp
  );

  modport ic (
    input  m_haddr, m_hwrite, m_hmastlock, m_hsize, m_hburst, m_hprot, m_htrans, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_hsel, s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans,
           s_hwdata, s_hreadyin,
    input  s_hrdata, s_hready, s_hresp
  );

endinterface

`default_nettype wire

// File: rtl/raifes_hasti_dbus_interconnect_default_slave.sv
// ============================================================================
// raifes_hasti_default_slave: two-cycle AHB-Lite ERROR responder for unmapped/timed-out accesses.
// Rev 1.0
// ============================================================================
`default_nettype none

module raifes_hasti_default_slave
  import raifes_hasti_dbus_interconnect_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  output logic                        o_hready,
  output logic [HASTI_RESP_WIDTH-1:0] o_hresp
);

  ds_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (i_start) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        o_hresp = HRESP_ERROR;
        state_d = i_start ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/raifes_hasti_dbus_interconnect.sv
// ============================================================================
// raifes_hasti_dbus_interconnect: single-master, NUM_SLAVES-slave HASTI dbus decode/return mux.
// Rev 1.0 -- optional hung-slave timeout enabled by defining RAIFES_DBUS_TIMEOUT_EN.
// ============================================================================
`default_nettype none

module raifes_hasti_dbus_interconnect
  import raifes_hasti_dbus_interconnect_pkg::*;
#(
  parameter int                          NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE     = {DBUS_PERIPH_BASE, DBUS_RAM_BASE},
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK     = {DBUS_REGION_MASK, DBUS_REGION_MASK},
  parameter int                          TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  raifes_hasti_dbus_interconnect_if.ic  bus,
  output logic [NUM_SLAVES-1:0]         timeout_flag
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("raifes_hasti_dbus_interconnect: NUM_SLAVES must be 1..8 and TIMEOUT_CYCLES >= 2");
  end

  logic                         w_active;
  logic [NUM_SLAVES-1:0]        w_hit;
  logic [NUM_SLAVES-1:0]        w_quarantine;
  dsel_t                        w_dec_code;
  dsel_t                        dsel_q, dsel_d;
  logic [HASTI_BUS_WIDTH-1:0]   w_sel_hrdata;
  logic                         w_sel_hready;
  logic [HASTI_RESP_WIDTH-1:0]  w_sel_hresp;
  logic                         w_m_hready;
  logic                         w_ds_start;
  logic                         w_ds_hready;
  logic [HASTI_RESP_WIDTH-1:0]  w_ds_hresp;
  logic                         w_timeout_fire;

  assign w_active = bus.m_htrans[1];

  // Quarantined slots fall through to the default slave
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_hit[i] = addr_hit(bus.m_haddr, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])
                 && !w_quarantine[i];
    end
  end

  always_comb begin
    w_dec_code = DSEL_DEFAULT;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_dec_code = DSEL_WIDTH'(i);
    end
  end

  always_comb begin
    bus.s_hsel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bus.s_hsel[i] = w_active && (w_dec_code == DSEL_WIDTH'(i));
    end
  end

  assign bus.s_haddr     = bus.m_haddr;
  assign bus.s_hwrite    = bus.m_hwrite;
  assign bus.s_hsize     = bus.m_hsize;
  assign bus.s_hburst    = bus.m_hburst;
  assign bus.s_hmastlock = bus.m_hmastlock;
  assign bus.s_hprot     = bus.m_hprot;
  assign bus.s_htrans    = bus.m_htrans;
  assign bus.s_hwdata    = bus.m_hwdata;
  assign bus.s_hreadyin  = w_m_hready;

  always_comb begin
    dsel_d = dsel_q;
    if (w_timeout_fire) begin
      dsel_d = DSEL_DEFAULT;
    end else if (w_m_hready) begin
      dsel_d = w_active ? w_dec_code : DSEL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsel_q <= DSEL_NONE;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  assign w_ds_start = w_timeout_fire || (w_m_hready && w_active && (w_dec_code == DSEL_DEFAULT));

  raifes_hasti_default_slave u_default_slave (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_ds_start),
    .o_hready (w_ds_hready),
    .o_hresp  (w_ds_hresp)
  );

  always_comb begin
    w_sel_hrdata = '0;
    w_sel_hready = 1'b1;
    w_sel_hresp  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == DSEL_WIDTH'(i)) begin
        w_sel_hrdata = bus.s_hrdata[HASTI_BUS_WIDTH*i +: HASTI_BUS_WIDTH];
        w_sel_hready = bus.s_hready[i];
        w_sel_hresp  = bus.s_hresp[HASTI_RESP_WIDTH*i +: HASTI_RESP_WIDTH];
      end
    end
  end

  always_comb begin
    bus.m_hrdata = '0;
    w_m_hready   = 1'b1;
    bus.m_hresp  = HRESP_OKAY;
    if (dsel_q == DSEL_DEFAULT) begin
      w_m_hready  = w_ds_hready;
      bus.m_hresp = w_ds_hresp;
    end else if (dsel_q != DSEL_NONE) begin
      bus.m_hrdata = w_sel_hrdata;
      w_m_hready   = w_sel_hready;
      bus.m_hresp  = w_sel_hresp;
    end
  end

  assign bus.m_hready = w_m_hready;

`ifdef RAIFES_DBUS_TIMEOUT_EN
  localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wait_w-1:0]    wait_q, wait_d;
  logic [NUM_SLAVES-1:0]  flag_q, flag_d;
  logic                   w_slave_wait;

  assign w_slave_wait = (dsel_q < DSEL_WIDTH'(NUM_SLAVES)) && !w_sel_hready;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of one data phase
  always_comb begin
    wait_d         = '0;
    flag_d         = flag_q;
    w_timeout_fire = 1'b0;
    if (w_slave_wait) begin
      if (wait_q == c_wait_w'(TIMEOUT_CYCLES - 1)) begin
        w_timeout_fire = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (dsel_q == DSEL_WIDTH'(i)) flag_d[i] = 1'b1;
        end
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
      flag_q <= '0;
    end else begin
      wait_q <= wait_d;
      flag_q <= flag_d;
    end
  end

  assign w_quarantine = flag_q;
  assign timeout_flag = flag_q;
`else
  assign w_timeout_fire = 1'b0;
  assign w_quarantine   = '0;
  assign timeout_flag   = '0;
`endif

endmodule

`default_nettype wire
